// File: rtl/mem_arb_if.sv
// Shared package and handshake interfaces for the core-to-SRAM arbiter.
// Fetch, load/store and SRAM macro bundles.
package mem_arb_pkg;
  localparam int XW = 32;

  typedef struct packed {
    logic [XW-1:0] addr;
    logic          wr;
    logic [XW-1:0] data;
    logic [3:0]    strobe;
  } ldst_req_t;

  typedef struct packed {
    logic [XW-1:0] data;
    logic          ok;
  } ldst_rsp_t;
endpackage

interface ifetch_if_t #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_pc;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_ir;

  modport slave (
    input  req_vld, req_pc, rsp_rdy,
    output req_rdy, rsp_vld, rsp_ir
  );
  modport master (
    output req_vld, req_pc, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_ir
  );
endinterface

interface ldst_if_t;
  import mem_arb_pkg::*;
  logic      req_vld;
  logic      req_rdy;
  ldst_req_t req_pkt;
  ldst_rsp_t rsp_pkt;

  modport slave (
    input  req_vld, req_pkt,
    output req_rdy, rsp_pkt
  );
  modport master (
    output req_vld, req_pkt,
    input  req_rdy, rsp_pkt
  );
endinterface

interface sram_if_t #(
  parameter int SAW = 15,
  parameter int DW  = 32
);
  logic [SAW-1:0] addr;
  logic           wen;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  rdata;

  modport master (
    output addr, wen, wdata,
    input  rdata
  );
  modport slave (
    input  addr, wen, wdata,
    output rdata
  );
endinterface

// File: rtl/mem_arb.sv
// Single-port SRAM arbiter: load/store priority with a fetch
// starvation guard; partial stores done as read-modify-write.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int             AW         = 32,
  parameter int             DW         = 32,
  parameter int             SAW        = 15,
  parameter logic [AW-1:0]  BASE       = 32'h0000_0000,
  parameter int             STARVE_MAX = 4,
  parameter logic [DW-1:0]  BAD_IR     = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst_n,
  ifetch_if_t.slave ifetch,
  ldst_if_t.slave   ldst,
  sram_if_t.master  sram
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE, LS_RD, RMW_RD, IF_RD
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   starve_cnt, starve_nx;
  logic            rsp_vld;
  logic [DW-1:0]   rsp_ir;
  logic            buf_ld;
  logic [DW-1:0]   buf_nx;
  ldst_req_t       pkt;
  ldst_rsp_t       rsp;
  logic            ls_rdy, if_rdy;
  logic [SAW-1:0]  s_addr;
  logic            s_wen;
  logic [DW-1:0]   s_wdata;
  logic [DW-1:0]   merged;
  logic            ls_win, if_win;
  logic            if_pend, ls_gnt, if_gnt;
  logic            unused;

  assign pkt     = ldst.req_pkt;
  assign ls_win  = pkt.addr[AW-1:SAW+2] == BASE[AW-1:SAW+2];
  assign if_win  = ifetch.req_pc[AW-1:SAW+2] == BASE[AW-1:SAW+2];
  assign if_pend = ifetch.req_vld && !rsp_vld;
  assign unused  = ^{pkt.addr[1:0], ifetch.req_pc[1:0]};

  // Grants only exist out of reset so outputs fall to idle at once
  assign ls_gnt = rst_n && state == IDLE && ldst.req_vld &&
                  !(if_pend && starve_cnt == CW'(STARVE_MAX));
  assign if_gnt = rst_n && state == IDLE && !ls_gnt && if_pend;

  always_comb begin
    merged = sram.rdata;
    for (int i = 0; i < DW / 8; i++) begin
      if (pkt.strobe[i]) merged[8*i +: 8] = pkt.data[8*i +: 8];
    end
  end

  always_comb begin
    state_nx  = state;
    starve_nx = starve_cnt;
    s_addr    = '0;
    s_wen     = 1'b0;
    s_wdata   = '0;
    ls_rdy    = 1'b0;
    if_rdy    = 1'b0;
    rsp       = '0;
    buf_ld    = 1'b0;
    buf_nx    = rsp_ir;
    unique case (state)
      IDLE: begin
        if (ls_gnt) begin
          starve_nx = if_pend ? starve_cnt + CW'(1) : '0;
          unique case (1'b1)
            !ls_win: ls_rdy = 1'b1;
            ls_win && pkt.wr && pkt.strobe == 4'hF: begin
              s_addr  = pkt.addr[SAW+1:2];
              s_wen   = 1'b1;
              s_wdata = pkt.data;
              ls_rdy  = 1'b1;
              rsp.ok  = 1'b1;
            end
            ls_win && pkt.wr && pkt.strobe == 4'h0: begin
              ls_rdy = 1'b1;
              rsp.ok = 1'b1;
            end
            ls_win && !pkt.wr: begin
              s_addr   = pkt.addr[SAW+1:2];
              state_nx = LS_RD;
            end
            default: begin
              s_addr   = pkt.addr[SAW+1:2];
              state_nx = RMW_RD;
            end
          endcase
        end else if (if_gnt) begin
          starve_nx = '0;
          if_rdy    = 1'b1;
          if (if_win) begin
            s_addr   = ifetch.req_pc[SAW+1:2];
            state_nx = IF_RD;
          end else begin
            buf_ld = 1'b1;
            buf_nx = BAD_IR;
          end
        end else begin
          starve_nx = '0;
        end
      end
      LS_RD: begin
        ls_rdy   = 1'b1;
        rsp.data = sram.rdata;
        rsp.ok   = 1'b1;
        state_nx = IDLE;
      end
      RMW_RD: begin
        s_addr   = pkt.addr[SAW+1:2];
        s_wen    = 1'b1;
        s_wdata  = merged;
        ls_rdy   = 1'b1;
        rsp.ok   = 1'b1;
        state_nx = IDLE;
      end
      IF_RD: begin
        buf_ld   = 1'b1;
        buf_nx   = sram.rdata;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rsp_vld    <= 1'b0;
      rsp_ir     <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      if (buf_ld) begin
        rsp_vld <= 1'b1;
        rsp_ir  <= buf_nx;
      end else if (rsp_vld && ifetch.rsp_rdy) begin
        rsp_vld <= 1'b0;
      end
    end
  end

  assign sram.addr      = s_addr;
  assign sram.wen       = s_wen;
  assign sram.wdata     = s_wdata;
  assign ldst.req_rdy   = ls_rdy;
  assign ldst.rsp_pkt   = rsp;
  assign ifetch.req_rdy = if_rdy;
  assign ifetch.rsp_vld = rsp_vld;
  assign ifetch.rsp_ir  = rsp_ir;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural SRAM
// and hand-computed expectations.
module tb_mem_arb;
  import mem_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  logic        pre_en;
  logic [14:0] pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:32767];

  logic [12:0] ls_exp;
  logic [12:0] if_exp;

  ifetch_if_t #(.AW(32), .DW(32)) ifi ();
  ldst_if_t                      lsi ();
  sram_if_t   #(.SAW(15), .DW(32)) sif ();

  mem_arb #(
    .AW(32), .DW(32), .SAW(15), .BASE(32'h0),
    .STARVE_MAX(4), .BAD_IR(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ifetch(ifi.slave),
    .ldst(lsi.slave),
    .sram(sif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (sif.wen) mem[sif.addr] <= sif.wdata;
    else sif.rdata <= mem[sif.addr];
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [14:0] a, input logic [31:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  task automatic ls_set(input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s);
    lsi.req_pkt = '{addr: a, wr: w, data: d, strobe: s};
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    ls_exp = 13'b0011111001111;
    if_exp = 13'b0100000010000;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    rst_n = 1'b0;
    ifi.req_vld = 1'b0;
    ifi.req_pc  = '0;
    ifi.rsp_rdy = 1'b0;
    lsi.req_vld = 1'b1;
    ls_set(32'h20, 1'b1, 32'hDEADBEEF, 4'hF);
    #2;
    chk("rst_ls_rdy", lsi.req_rdy, 0);
    chk("rst_wen", sif.wen, 0);
    chk("rst_addr", sif.addr, 0);
    chk("rst_wdata", sif.wdata, 0);
    chk("rst_if_rdy", ifi.req_rdy, 0);
    chk("rst_rsp_vld", ifi.rsp_vld, 0);
    chk("rst_rsp_ir", ifi.rsp_ir, 0);
    chk("rst_rsp_pkt", lsi.rsp_pkt, 0);
    lsi.req_vld = 1'b0;
    poke(15'd4, 32'h00500093);
    rst_n = 1'b1;

    // fetch pc=0x10
    step();
    ifi.req_vld = 1'b1;
    ifi.req_pc  = 32'h10;
    #1;
    chk("if_rdy", ifi.req_rdy, 1);
    chk("if_addr", sif.addr, 4);
    step();
    ifi.req_vld = 1'b0;
    #1;
    chk("if_c1_vld", ifi.rsp_vld, 0);
    step();
    #1;
    chk("if_c2_vld", ifi.rsp_vld, 1);
    chk("if_c2_ir", ifi.rsp_ir, 32'h00500093);
    ifi.req_vld = 1'b1;
    #1;
    chk("if_full_rdy", ifi.req_rdy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("hold_vld", ifi.rsp_vld, 1);
      chk("hold_ir", ifi.rsp_ir, 32'h00500093);
      chk("hold_rdy", ifi.req_rdy, 0);
    end
    step();
    ifi.rsp_rdy = 1'b1;
    #1;
    chk("drain_rdy", ifi.req_rdy, 0);
    step();
    ifi.req_vld = 1'b0;
    #1;
    chk("drained_vld", ifi.rsp_vld, 0);

    // full-word store then load
    step();
    lsi.req_vld = 1'b1;
    ls_set(32'h20, 1'b1, 32'hAABBCCDD, 4'hF);
    #1;
    chk("st_rdy", lsi.req_rdy, 1);
    chk("st_wen", sif.wen, 1);
    chk("st_addr", sif.addr, 8);
    chk("st_wdata", sif.wdata, 32'hAABBCCDD);
    chk("st_rsp", lsi.rsp_pkt, 33'h1);
    step();
    lsi.req_vld = 1'b0;
    #1;
    chk("st_mem", mem[8], 32'hAABBCCDD);
    ls_set(32'h20, 1'b0, 32'h0, 4'h0);
    lsi.req_vld = 1'b1;
    #1;
    chk("ld_c0_rdy", lsi.req_rdy, 0);
    chk("ld_c0_wen", sif.wen, 0);
    chk("ld_c0_addr", sif.addr, 8);
    step();
    #1;
    chk("ld_rdy", lsi.req_rdy, 1);
    chk("ld_rsp", lsi.rsp_pkt, {32'hAABBCCDD, 1'b1});
    step();
    lsi.req_vld = 1'b0;

    // partial store as read-modify-write
    poke(15'd8, 32'h11223344);
    ls_set(32'h20, 1'b1, 32'hAABBCCDD, 4'b0101);
    lsi.req_vld = 1'b1;
    #1;
    chk("rmw_c0_rdy", lsi.req_rdy, 0);
    chk("rmw_c0_wen", sif.wen, 0);
    step();
    #1;
    chk("rmw_rdy", lsi.req_rdy, 1);
    chk("rmw_wen", sif.wen, 1);
    chk("rmw_wdata", sif.wdata, 32'h11BB33DD);
    chk("rmw_rsp", lsi.rsp_pkt, 33'h1);
    step();
    lsi.req_vld = 1'b0;
    #1;
    chk("rmw_mem", mem[8], 32'h11BB33DD);

    // zero-strobe store touches nothing
    ls_set(32'h20, 1'b1, 32'h55555555, 4'h0);
    lsi.req_vld = 1'b1;
    #1;
    chk("z_rdy", lsi.req_rdy, 1);
    chk("z_wen", sif.wen, 0);
    chk("z_rsp", lsi.rsp_pkt, 33'h1);
    step();
    lsi.req_vld = 1'b0;
    #1;
    chk("z_mem", mem[8], 32'h11BB33DD);

    // out-of-window load and fetch
    ls_set(32'h0002_0000, 1'b0, 32'h0, 4'h0);
    lsi.req_vld = 1'b1;
    #1;
    chk("oow_rdy", lsi.req_rdy, 1);
    chk("oow_rsp", lsi.rsp_pkt, 0);
    chk("oow_wen", sif.wen, 0);
    step();
    lsi.req_vld = 1'b0;
    ifi.req_vld = 1'b1;
    ifi.req_pc  = 32'h0002_0000;
    #1;
    chk("oow_if_rdy", ifi.req_rdy, 1);
    chk("oow_if_wen", sif.wen, 0);
    step();
    ifi.req_vld = 1'b0;
    #1;
    chk("oow_if_vld", ifi.rsp_vld, 1);
    chk("oow_if_ir", ifi.rsp_ir, 32'h0);

    // starvation guard
    step();
    ifi.req_vld = 1'b1;
    ifi.req_pc  = 32'h10;
    lsi.req_vld = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) step();
      ls_set(32'h24, 1'b1, 32'h100 + c, 4'hF);
      #1;
      chk($sformatf("stv_ls_c%0d", c), lsi.req_rdy, ls_exp[c]);
      chk($sformatf("stv_if_c%0d", c), ifi.req_rdy, if_exp[c]);
      if (c == 6) chk("stv_ir", ifi.rsp_ir, 32'h00500093);
    end
    step();
    ifi.req_vld = 1'b0;
    lsi.req_vld = 1'b0;
    step();

    // async reset during RMW_RD with a full fetch buffer
    ifi.rsp_rdy = 1'b0;
    poke(15'd8, 32'h11223344);
    ifi.req_vld = 1'b1;
    ifi.req_pc  = 32'h10;
    #1;
    chk("rr_if_rdy", ifi.req_rdy, 1);
    step();
    ifi.req_vld = 1'b0;
    step();
    #1;
    chk("rr_full", ifi.rsp_vld, 1);
    ls_set(32'h20, 1'b1, 32'hAABBCCDD, 4'b0011);
    lsi.req_vld = 1'b1;
    #1;
    chk("rr_c0_rdy", lsi.req_rdy, 0);
    step();
    rst_n = 1'b0;
    #1;
    chk("rr_wen", sif.wen, 0);
    chk("rr_ls_rdy", lsi.req_rdy, 0);
    chk("rr_addr", sif.addr, 0);
    chk("rr_wdata", sif.wdata, 0);
    chk("rr_rsp", lsi.rsp_pkt, 0);
    chk("rr_vld", ifi.rsp_vld, 0);
    chk("rr_ir", ifi.rsp_ir, 0);
    step();
    lsi.req_vld = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    #1;
    chk("rr_mem", mem[8], 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
